sram_wr_arb: RTL and testbench

//  Shares the single SRAM write path between NUM_PORTS datasg segmenter instances, one per input port.

---
 rtl/sram_wr_arb_pkg.sv | 18 +
 rtl/sram_wr_arb_rr_prio_pick.sv | 41 ++++
 rtl/sram_wr_arb.sv | 147 ++++++++++++++
 tb/tb_sram_wr_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wr_arb_pkg.sv
// Shared definitions for the SRAM write-path arbiter: default geometry,
// timeout width and FSM state encoding.
package sram_wr_arb_pkg;

  localparam int NUM_PORTS_DEF = 16;
  localparam int DATA_W_DEF    = 64;
  localparam int ADDR_W_DEF    = 12;
  localparam int DES_W_DEF     = 4;
  localparam int PRIO_W_DEF    = 3;
  localparam int TIMEOUT_DEF   = 255;
  localparam int TCNT_W        = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sram_wr_arb_rr_prio_pick.sv
// Combinational winner selection: highest priority among requesters,
// ties resolved by the first requester at or after rr_ptr.
module rr_prio_pick #(
  parameter int NUM_PORTS = 16,
  parameter int PRIO_W    = 3,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*PRIO_W-1:0] prio,
  input  logic [IDX_W-1:0]            rr_ptr,
  output logic [IDX_W-1:0]            win_idx,
  output logic                        win_valid
);

  logic [PRIO_W-1:0] max_prio;
  int                j;

  always_comb begin
    max_prio  = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && (prio[i*PRIO_W +: PRIO_W] > max_prio)) begin
        max_prio = prio[i*PRIO_W +: PRIO_W];
      end
    end
    // Walk the ports starting at rr_ptr so equal-priority ties rotate.
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_PORTS) begin
        j = j - NUM_PORTS;
      end
      if (!win_valid && req[j] && (prio[j*PRIO_W +: PRIO_W] == max_prio)) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sram_wr_arb.sv
// Arbitrates the single SRAM write path between datasg segmenters; the
// winner keeps the path until its end-of-packet word or a stall timeout.
module sram_wr_arb
  import sram_wr_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DES_W     = DES_W_DEF,
  parameter int PRIO_W    = PRIO_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        eop,
  input  logic [NUM_PORTS*PRIO_W-1:0] prio_in,
  input  logic [NUM_PORTS*DES_W-1:0]  des_in,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic                        sram_ready,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS-1:0]        busy,
  output logic [NUM_PORTS-1:0]        ack,
  output logic                        sram_wr_en,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_data,
  output logic [DES_W-1:0]            sram_des,
  output logic [PRIO_W-1:0]           sram_prio,
  output logic                        abort
);

  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_nxt;
  logic [TCNT_W-1:0]    tcnt, tcnt_nxt;
  logic [NUM_PORTS-1:0] grant_nxt, busy_nxt;
  logic                 wr_en_nxt, abort_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [DATA_W-1:0]    data_nxt;
  logic [DES_W-1:0]     des_nxt;
  logic [PRIO_W-1:0]    prio_nxt;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic                 accept;

  rr_prio_pick #(
    .NUM_PORTS(NUM_PORTS),
    .PRIO_W   (PRIO_W)
  ) u_pick (
    .req      (req),
    .prio     (prio_in),
    .rr_ptr   (rr_ptr),
    .win_idx  (win_idx),
    .win_valid(win_valid)
  );

  assign accept = (state == ST_XFER) && req[owner] && sram_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      tcnt       <= '0;
      grant      <= '0;
      busy       <= '0;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      sram_data  <= '0;
      sram_des   <= '0;
      sram_prio  <= '0;
      abort      <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_nxt;
      tcnt       <= tcnt_nxt;
      grant      <= grant_nxt;
      busy       <= busy_nxt;
      sram_wr_en <= wr_en_nxt;
      sram_addr  <= addr_nxt;
      sram_data  <= data_nxt;
      sram_des   <= des_nxt;
      sram_prio  <= prio_nxt;
      abort      <= abort_nxt;
    end
  end

  // Non-write cycles keep sram_* at their last values; only the strobe drops.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    tcnt_nxt  = tcnt;
    grant_nxt = grant;
    busy_nxt  = busy;
    wr_en_nxt = 1'b0;
    abort_nxt = 1'b0;
    addr_nxt  = sram_addr;
    data_nxt  = sram_data;
    des_nxt   = sram_des;
    prio_nxt  = sram_prio;
    case (state)
      ST_IDLE: begin
        tcnt_nxt = '0;
        if (win_valid) begin
          state_nxt = ST_XFER;
          owner_nxt = win_idx;
          grant_nxt = NUM_PORTS'(1) << win_idx;
          busy_nxt  = ~(NUM_PORTS'(1) << win_idx);
        end
      end
      ST_XFER: begin
        if (accept) begin
          wr_en_nxt = 1'b1;
          addr_nxt  = addr_in[owner*ADDR_W +: ADDR_W];
          data_nxt  = data_in[owner*DATA_W +: DATA_W];
          des_nxt   = des_in[owner*DES_W +: DES_W];
          prio_nxt  = prio_in[owner*PRIO_W +: PRIO_W];
          tcnt_nxt  = '0;
        end else if (tcnt != TCNT_W'(TIMEOUT)) begin
          tcnt_nxt = tcnt + TCNT_W'(1);
        end else begin
          tcnt_nxt  = '0;
          abort_nxt = 1'b1;
        end
        if ((accept && eop[owner]) || abort_nxt) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          busy_nxt  = '0;
          rr_nxt    = (owner == IDX_W'(NUM_PORTS - 1)) ? '0 : owner + IDX_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (accept) begin
      ack[owner] = 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_wr_arb.sv
// Directed bench for sram_wr_arb: a vector table for the main packet flow
// plus hand-written sequences for round-robin, timeout and reset corners.
module tb_sram_wr_arb;

  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   req, eop, grant, busy, ack;
  logic [47:0]   prio_in;
  logic [63:0]   des_in;
  logic [191:0]  addr_in;
  logic [1023:0] data_in;
  logic          sram_ready, sram_wr_en, abort;
  logic [11:0]   sram_addr;
  logic [63:0]   sram_data;
  logic [3:0]    sram_des;
  logic [2:0]    sram_prio;

  logic [2:0]  prio_a [NP];
  logic [3:0]  des_a  [NP];
  logic [11:0] addr_a [NP];
  logic [63:0] data_a [NP];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] req;
    logic [15:0] eop;
    logic        rdy;
    logic [11:0] wa;
    logic [15:0] exp_ack;
    logic [15:0] exp_grant;
    logic        exp_wr;
    logic [11:0] exp_addr;
    int          exp_port;
  } vec_t;

  vec_t vecs [12];

  sram_wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .eop       (eop),
    .prio_in   (prio_in),
    .des_in    (des_in),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .sram_ready(sram_ready),
    .grant     (grant),
    .busy      (busy),
    .ack       (ack),
    .sram_wr_en(sram_wr_en),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_des  (sram_des),
    .sram_prio (sram_prio),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      prio_in[i*3 +: 3]   = prio_a[i];
      des_in[i*4 +: 4]    = des_a[i];
      addr_in[i*12 +: 12] = addr_a[i];
      data_in[i*64 +: 64] = data_a[i];
    end
  end

  function automatic logic [63:0] word_data(input int p, input logic [11:0] wa);
    logic [3:0] pn;
    pn = p[3:0];
    return {48'h0, pn, wa};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [11:0] wa);
    for (int p = 0; p < NP; p++) begin
      addr_a[p] = wa;
      data_a[p] = word_data(p, wa);
      des_a[p]  = 4'(15 - p);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    req        = '0;
    eop        = '0;
    sram_ready = 1'b1;
    for (int p = 0; p < NP; p++) prio_a[p] = '0;
    set_words(12'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [15:0] exp_busy;
    req        = v.req;
    eop        = v.eop;
    sram_ready = v.rdy;
    set_words(v.wa);
    #1;
    checkOutput($sformatf("vec%0d_ack", idx), 64'(ack), 64'(v.exp_ack));
    tick();
    exp_busy = (v.exp_grant == 16'h0) ? 16'h0 : ~v.exp_grant;
    checkOutput($sformatf("vec%0d_grant", idx), 64'(grant), 64'(v.exp_grant));
    checkOutput($sformatf("vec%0d_busy", idx), 64'(busy), 64'(exp_busy));
    checkOutput($sformatf("vec%0d_wr_en", idx), 64'(sram_wr_en), 64'(v.exp_wr));
    checkOutput($sformatf("vec%0d_addr", idx), 64'(sram_addr), 64'(v.exp_addr));
    if (v.exp_port >= 0) begin
      checkOutput($sformatf("vec%0d_data", idx), sram_data, word_data(v.exp_port, v.exp_addr));
      checkOutput($sformatf("vec%0d_des", idx), 64'(sram_des), 64'(15 - v.exp_port));
      checkOutput($sformatf("vec%0d_prio", idx), 64'(sram_prio), (v.exp_port == 9) ? 64'd6 : 64'd2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order [4];
    int wr_seen;
    int n_wait;
    logic seen;

    // Port 9 (prio 6) beats port 5 (prio 2); stall mid-packet; then port 5.
    vecs[0]  = '{16'h0220, 16'h0000, 1'b1, 12'd0, 16'h0000, 16'h0200, 1'b0, 12'd0, -1};
    vecs[1]  = '{16'h0220, 16'h0000, 1'b1, 12'd1, 16'h0200, 16'h0200, 1'b1, 12'd1,  9};
    vecs[2]  = '{16'h0220, 16'h0000, 1'b1, 12'd2, 16'h0200, 16'h0200, 1'b1, 12'd2,  9};
    vecs[3]  = '{16'h0220, 16'h0000, 1'b0, 12'd3, 16'h0000, 16'h0200, 1'b0, 12'd2, -1};
    vecs[4]  = '{16'h0220, 16'h0000, 1'b0, 12'd3, 16'h0000, 16'h0200, 1'b0, 12'd2, -1};
    vecs[5]  = '{16'h0220, 16'h0200, 1'b0, 12'd3, 16'h0000, 16'h0200, 1'b0, 12'd2, -1};
    vecs[6]  = '{16'h0220, 16'h0000, 1'b1, 12'd3, 16'h0200, 16'h0200, 1'b1, 12'd3,  9};
    vecs[7]  = '{16'h0220, 16'h0000, 1'b1, 12'd4, 16'h0200, 16'h0200, 1'b1, 12'd4,  9};
    vecs[8]  = '{16'h0220, 16'h0200, 1'b1, 12'd5, 16'h0200, 16'h0000, 1'b1, 12'd5,  9};
    vecs[9]  = '{16'h0020, 16'h0000, 1'b1, 12'd6, 16'h0000, 16'h0020, 1'b0, 12'd5, -1};
    vecs[10] = '{16'h0020, 16'h0020, 1'b1, 12'd7, 16'h0020, 16'h0000, 1'b1, 12'd7,  5};
    vecs[11] = '{16'h0000, 16'h0000, 1'b1, 12'd8, 16'h0000, 16'h0000, 1'b0, 12'd7, -1};

    // Reset with every port requesting, then first grant to port 0.
    rst        = 1'b0;
    req        = 16'hFFFF;
    eop        = '0;
    sram_ready = 1'b1;
    for (int p = 0; p < NP; p++) prio_a[p] = '0;
    set_words(12'h0);
    repeat (2) tick();
    checkOutput("t1_rst_grant", 64'(grant), 64'h0);
    checkOutput("t1_rst_busy", 64'(busy), 64'h0);
    checkOutput("t1_rst_wr_en", 64'(sram_wr_en), 64'h0);
    checkOutput("t1_rst_ack", 64'(ack), 64'h0);
    rst = 1'b1;
    tick();
    checkOutput("t1_first_grant", 64'(grant), 64'h0001);
    checkOutput("t1_first_busy", 64'(busy), 64'hFFFE);

    do_reset();
    prio_a[9] = 3'd6;
    prio_a[5] = 3'd2;
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Equal-priority round-robin over ports 3, 7, 12 with 2-word packets.
    do_reset();
    prio_a[3]  = 3'd4;
    prio_a[7]  = 3'd4;
    prio_a[12] = 3'd4;
    req   = 16'h1088;
    set_words(12'h033);
    order = '{3, 7, 12, 3};
    for (int k = 0; k < 4; k++) begin
      eop = '0;
      tick();
      checkOutput($sformatf("t3_grant%0d", k), 64'(grant), 64'(16'(1) << order[k]));
      tick();
      checkOutput($sformatf("t3_w1_wr%0d", k), 64'(sram_wr_en), 64'h1);
      eop = 16'(1) << order[k];
      tick();
      checkOutput($sformatf("t3_w2_wr%0d", k), 64'(sram_wr_en), 64'h1);
      checkOutput($sformatf("t3_w2_data%0d", k), sram_data, word_data(order[k], 12'h033));
      checkOutput($sformatf("t3_release%0d", k), 64'(grant), 64'h0);
    end
    eop = '0;

    // Owner stalls by dropping req until the timeout forces release.
    do_reset();
    prio_a[2] = 3'd1;
    req       = 16'h0044;
    tick();
    checkOutput("t5_grant", 64'(grant), 64'h0004);
    set_words(12'h020);
    #1;
    checkOutput("t5_ack", 64'(ack), 64'h0004);
    tick();
    checkOutput("t5_wr_en", 64'(sram_wr_en), 64'h1);
    req     = 16'h0040;
    seen    = 1'b0;
    wr_seen = 0;
    n_wait  = 0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      tick();
      if (sram_wr_en) wr_seen++;
      if (abort) begin
        seen   = 1'b1;
        n_wait = c;
      end
    end
    checkOutput("t5_abort_seen", 64'(seen), 64'h1);
    checkOutput("t5_no_write", 64'(wr_seen), 64'h0);
    if (seen) begin
      checkOutput("t5_abort_delay", 64'(n_wait >= 255 && n_wait <= 257), 64'h1);
      checkOutput("t5_abort_grant", 64'(grant), 64'h0);
      checkOutput("t5_abort_busy", 64'(busy), 64'h0);
    end
    tick();
    checkOutput("t5_abort_pulse", 64'(abort), 64'h0);
    checkOutput("t5_next_grant", 64'(grant), 64'h0040);

    // Async reset in the middle of port 4's packet; rr_ptr must restart at 0.
    do_reset();
    req = 16'h0012;
    tick();
    checkOutput("t6_grant1", 64'(grant), 64'h0002);
    eop = 16'h0002;
    tick();
    checkOutput("t6_pkt1_wr", 64'(sram_wr_en), 64'h1);
    eop = '0;
    tick();
    checkOutput("t6_grant4", 64'(grant), 64'h0010);
    set_words(12'h001);
    tick();
    checkOutput("t6_w1_wr", 64'(sram_wr_en), 64'h1);
    set_words(12'h002);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_grant", 64'(grant), 64'h0);
    checkOutput("t6_rst_busy", 64'(busy), 64'h0);
    checkOutput("t6_rst_wr_en", 64'(sram_wr_en), 64'h0);
    checkOutput("t6_rst_addr", 64'(sram_addr), 64'h0);
    checkOutput("t6_rst_data", sram_data, 64'h0);
    checkOutput("t6_rst_ack", 64'(ack), 64'h0);
    checkOutput("t6_rst_abort", 64'(abort), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checkOutput("t6_restart_grant", 64'(grant), 64'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
